// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared types and constants for the MEM-stage load/store unit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Width of a counter that must be able to hold max_wait
  function automatic int wait_w(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// load_align : picks the addressed byte/half of a read word and extends it
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[{byte_off, 3'b000} +: 8];
    w_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    result = {{24{w_byte[7]}}, w_byte};
      F3_H:    result = {{16{w_half[15]}}, w_half};
      F3_BU:   result = {24'h0, w_byte};
      F3_HU:   result = {16'h0, w_half};
      default: result = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit : MEM-stage load/store unit with req/ack bus and timeout
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] alu_result,
  input  logic        reg_write_in,
  input  logic [4:0]  rd_idx_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wb_data_out,
  output logic        reg_write_out,
  output logic [4:0]  rd_idx_out,
  output logic        stall_out,
  output logic        access_err,
  output logic        bus_err
);

  localparam int              WAIT_W      = wait_w(MAX_WAIT);
  localparam logic [WAIT_W-1:0] c_last_wait = WAIT_W'(MAX_WAIT - 1);

  mem_state_t        r_state, w_next_state;
  logic [WAIT_W-1:0] r_cnt;
  logic              r_req, r_we, r_read, r_err;
  logic [29:0]       r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata, r_result;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;

  logic        w_mem_op, w_f3_ok, w_misalign, w_illegal, w_accept, w_timeout;
  logic [3:0]  w_lanes;
  logic [31:0] w_wdata, w_load;

  assign w_mem_op   = valid_in & (mem_read | mem_write);
  assign w_f3_ok    = (funct3 == F3_B) | (funct3 == F3_H) | (funct3 == F3_W) |
                      (mem_read & ((funct3 == F3_BU) | (funct3 == F3_HU)));
  // funct3[1:0] == 01 covers both H and HU
  assign w_misalign = ((funct3[1:0] == 2'b01) & addr[0]) |
                      ((funct3 == F3_W) & (addr[1:0] != 2'b00));
  assign w_illegal  = (mem_read & mem_write) | ~w_f3_ok | w_misalign;
  assign w_accept   = w_mem_op & ~w_illegal;
  assign w_timeout  = ~dmem_ack & (r_cnt == c_last_wait);

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        w_lanes = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_lanes = 4'b0011 << addr[1:0];
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_lanes = 4'b1111;
        w_wdata = store_data;
      end
    endcase
  end

  load_align u_load_align (
    .rdata    (dmem_rdata),
    .byte_off (r_off),
    .funct3   (r_f3),
    .result   (w_load)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_read   <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_result <= '0;
      r_f3     <= '0;
      r_off    <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req    <= 1'b1;
            r_we     <= mem_write;
            r_read   <= mem_read;
            r_err    <= 1'b0;
            r_addr   <= addr[31:2];
            r_be     <= mem_write ? w_lanes : 4'b0000;
            r_wdata  <= w_wdata;
            r_result <= '0;
            r_f3     <= funct3;
            r_off    <= addr[1:0];
            r_cnt    <= '0;
          end
        end
        BUSY: begin
          // An ack in the final wait cycle takes priority over the abort
          if (dmem_ack) begin
            r_req    <= 1'b0;
            r_result <= r_read ? w_load : '0;
            r_cnt    <= '0;
          end else if (w_timeout) begin
            r_req    <= 1'b0;
            r_err    <= 1'b1;
            r_result <= '0;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state  = r_state;
    wb_data_out   = '0;
    reg_write_out = 1'b0;
    stall_out     = 1'b0;
    access_err    = 1'b0;
    bus_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          if (w_illegal) begin
            access_err = 1'b1;
          end else begin
            stall_out    = 1'b1;
            w_next_state = BUSY;
          end
        end else begin
          wb_data_out   = alu_result;
          reg_write_out = reg_write_in & valid_in;
        end
      end
      BUSY: begin
        stall_out = 1'b1;
        if (dmem_ack || w_timeout) w_next_state = DONE;
      end
      DONE: begin
        wb_data_out   = r_result;
        reg_write_out = r_read & reg_write_in & ~r_err;
        bus_err       = r_err;
        w_next_state  = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    if (reset) begin
      wb_data_out   = '0;
      reg_write_out = 1'b0;
      stall_out     = 1'b0;
      access_err    = 1'b0;
      bus_err       = 1'b0;
    end
  end

  assign rd_idx_out = reset ? 5'd0 : rd_idx_in;
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = {r_addr, 2'b00};
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;

endmodule

`default_nettype wire
